// File: rtl/czonotope_unload.sv
// czonotope_unload: streams a constrained zonotope (c, G, A, b) out of four
// synchronous-read result memories as one word per valid/ready handshake.
// Order: c, then G column-major, then A column-major, then b.
// A 2-entry output FIFO absorbs the one-cycle memory latency plus the capture
// register, so the stream runs at one word per cycle while m_ready stays high.
// Optional feature macro: CZ_UNLOAD_NAN_FLAG_EN. When defined, nan_o is a
// sticky flag for handshaken words with an all-ones exponent (NaN/Inf).
module czonotope_unload #(
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NW         = $clog2(NMAX) + 1,
  parameter int GW         = $clog2(NGMAX) + 1,
  parameter int CW         = $clog2(NCMAX) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NW-1:0]         n_i,
  input  logic [GW-1:0]         ng_i,
  input  logic [CW-1:0]         nc_i,
  output logic [NW-1:0]         c_addr,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic [NW-1:0]         G_raddr,
  output logic [GW-1:0]         G_caddr,
  input  logic [DATA_WIDTH-1:0] G_rdata,
  output logic [CW-1:0]         A_raddr,
  output logic [GW-1:0]         A_caddr,
  input  logic [DATA_WIDTH-1:0] A_rdata,
  output logic [CW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            m_sec,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  nan_o
);

  localparam int IW = (NW > CW) ? NW : CW;  // shared row counter width
  localparam int EW = DATA_WIDTH + 3;       // FIFO entry: {last, sec, data}

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_C     = 3'd1;
  localparam logic [2:0] S_G     = 3'd2;
  localparam logic [2:0] S_A     = 3'd3;
  localparam logic [2:0] S_B     = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]    state_reg;
  logic [IW-1:0] row_reg;
  logic [GW-1:0] col_reg;
  logic [NW-1:0] n_reg;
  logic [GW-1:0] ng_reg;
  logic [CW-1:0] nc_reg;
  logic          done_reg;
  logic          err_reg;

  // Read issued last cycle: its data is on the memory outputs this cycle.
  logic          pend_reg;
  logic [1:0]    pend_sec_reg;
  logic          pend_last_reg;

  logic [EW-1:0] fifo_reg [0:1];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;

  logic          in_sec;
  logic          pop;
  logic [2:0]    occ;
  logic          issue;
  logic          sec_end;
  logic          row_end;
  logic [2:0]    next_sec;
  logic [1:0]    tag;
  logic          range_bad;
  logic [IW-1:0] n_last;
  logic [IW-1:0] nc_last;
  logic [GW-1:0] ng_last;
  logic [EW-1:0] head;
  logic [DATA_WIDTH-1:0] wr_data;

  assign in_sec    = (state_reg == S_C) || (state_reg == S_G) ||
                     (state_reg == S_A) || (state_reg == S_B);
  assign head      = fifo_reg[rd_ptr_reg];
  assign m_valid   = (count_reg != 2'd0);
  assign pop       = m_valid && m_ready;
  // Space check counts the word already in flight and frees a same-cycle pop.
  assign occ       = {1'b0, count_reg} + {2'b00, pend_reg} - {2'b00, pop};
  assign issue     = in_sec && (occ < 3'd2);
  assign range_bad = (n_i > NW'(NMAX)) || (ng_i > GW'(NGMAX)) || (nc_i > CW'(NCMAX));
  assign n_last    = IW'(n_reg) - IW'(1);
  assign nc_last   = IW'(nc_reg) - IW'(1);
  assign ng_last   = ng_reg - GW'(1);

  assign m_data = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_sec  = m_valid ? head[DATA_WIDTH+1:DATA_WIDTH] : 2'd0;
  assign m_last = m_valid ? head[DATA_WIDTH+2] : 1'b0;
  assign busy   = (state_reg != S_IDLE);
  assign done   = done_reg;
  assign err    = err_reg;

  // Addresses follow the walk counters only in their own section, else 0.
  assign c_addr  = (state_reg == S_C) ? row_reg[NW-1:0] : '0;
  assign G_raddr = (state_reg == S_G) ? row_reg[NW-1:0] : '0;
  assign G_caddr = (state_reg == S_G) ? col_reg : '0;
  assign A_raddr = (state_reg == S_A) ? row_reg[CW-1:0] : '0;
  assign A_caddr = (state_reg == S_A) ? col_reg : '0;
  assign b_addr  = (state_reg == S_B) ? row_reg[CW-1:0] : '0;

  // Per-section end-of-row / end-of-section detection and section chaining.
  always_comb begin
    sec_end  = 1'b0;
    row_end  = 1'b0;
    next_sec = S_DRAIN;
    tag      = 2'd0;
    case (state_reg)
      S_C: begin
        row_end  = (row_reg == n_last);
        sec_end  = row_end;
        next_sec = (ng_reg != '0) ? S_G : ((nc_reg != '0) ? S_B : S_DRAIN);
        tag      = 2'd0;
      end
      S_G: begin
        row_end  = (row_reg == n_last);
        sec_end  = row_end && (col_reg == ng_last);
        next_sec = (nc_reg != '0) ? S_A : S_DRAIN;
        tag      = 2'd1;
      end
      S_A: begin
        row_end  = (row_reg == nc_last);
        sec_end  = row_end && (col_reg == ng_last);
        next_sec = S_B;
        tag      = 2'd2;
      end
      S_B: begin
        row_end  = (row_reg == nc_last);
        sec_end  = row_end;
        next_sec = S_DRAIN;
        tag      = 2'd3;
      end
      default: ;
    endcase
  end

  // Select the memory whose read was issued last cycle.
  always_comb begin
    wr_data = c_rdata;
    case (pend_sec_reg)
      2'd1:    wr_data = G_rdata;
      2'd2:    wr_data = A_rdata;
      2'd3:    wr_data = b_rdata;
      default: wr_data = c_rdata;
    endcase
  end

  // Transfer FSM: start/range check, walk counters, completion pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      n_reg     <= '0;
      ng_reg    <= '0;
      nc_reg    <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            n_reg   <= n_i;
            ng_reg  <= ng_i;
            nc_reg  <= nc_i;
            err_reg <= range_bad;
            row_reg <= '0;
            col_reg <= '0;
            if (range_bad || (n_i == '0)) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= S_C;
            end
          end
        end
        S_DRAIN: begin
          if (pop && head[DATA_WIDTH+2]) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          if (issue) begin
            if (sec_end) begin
              state_reg <= next_sec;
              row_reg   <= '0;
              col_reg   <= '0;
            end else if (row_end) begin
              row_reg <= '0;
              col_reg <= col_reg + GW'(1);
            end else begin
              row_reg <= row_reg + IW'(1);
            end
          end
        end
      endcase
    end
  end

  // Track the read in flight so its data is captured one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_reg      <= 1'b0;
      pend_sec_reg  <= 2'd0;
      pend_last_reg <= 1'b0;
    end else begin
      pend_reg      <= issue;
      pend_sec_reg  <= tag;
      pend_last_reg <= issue && sec_end && (next_sec == S_DRAIN);
    end
  end

  // Two-entry output FIFO; writes are only possible when space was reserved.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_reg[0] <= '0;
      fifo_reg[1] <= '0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
    end else begin
      if (pend_reg) begin
        fifo_reg[wr_ptr_reg] <= {pend_last_reg, pend_sec_reg, wr_data};
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, pend_reg} - {1'b0, pop};
    end
  end

`ifdef CZ_UNLOAD_NAN_FLAG_EN
  logic nan_reg;

  // Sticky non-finite detector on accepted words; cleared by a new start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nan_reg <= 1'b0;
    end else if ((state_reg == S_IDLE) && start_i) begin
      nan_reg <= 1'b0;
    end else if (pop && (&m_data[30:23])) begin
      nan_reg <= 1'b1;
    end
  end

  assign nan_o = nan_reg;
`else
  assign nan_o = 1'b0;
`endif

endmodule

// File: tb/tb_czonotope_unload.sv
// Self-checking bench for czonotope_unload: directed transfers with random
// memory contents and random back-pressure, checked against a reference
// stream built directly from the walk order of c, G, A and b.
module tb_czonotope_unload;
  localparam int NMAX  = 3;
  localparam int NGMAX = 15;
  localparam int NCMAX = 12;
  localparam int DW    = 32;
  localparam int NW    = $clog2(NMAX) + 1;
  localparam int GW    = $clog2(NGMAX) + 1;
  localparam int CW    = $clog2(NCMAX) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic [NW-1:0] n_i = '0;
  logic [GW-1:0] ng_i = '0;
  logic [CW-1:0] nc_i = '0;
  logic [NW-1:0] c_addr, G_raddr;
  logic [GW-1:0] G_caddr, A_caddr;
  logic [CW-1:0] A_raddr, b_addr;
  logic [DW-1:0] c_rdata, G_rdata, A_rdata, b_rdata;
  logic          m_valid, m_last, busy, done, err, nan_o;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    m_sec;

  czonotope_unload dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i),
    .n_i(n_i), .ng_i(ng_i), .nc_i(nc_i),
    .c_addr(c_addr), .c_rdata(c_rdata),
    .G_raddr(G_raddr), .G_caddr(G_caddr), .G_rdata(G_rdata),
    .A_raddr(A_raddr), .A_caddr(A_caddr), .A_rdata(A_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sec(m_sec), .m_last(m_last), .busy(busy), .done(done),
    .err(err), .nan_o(nan_o)
  );

  // Result memories with one-cycle synchronous read.
  logic [DW-1:0] c_mem [0:NMAX-1];
  logic [DW-1:0] g_mem [0:NMAX-1][0:NGMAX-1];
  logic [DW-1:0] a_mem [0:NCMAX-1][0:NGMAX-1];
  logic [DW-1:0] b_mem [0:NCMAX-1];

  always @(posedge clk) begin
    c_rdata <= (int'(c_addr) < NMAX) ? c_mem[c_addr] : '0;
    G_rdata <= (int'(G_raddr) < NMAX && int'(G_caddr) < NGMAX) ? g_mem[G_raddr][G_caddr] : '0;
    A_rdata <= (int'(A_raddr) < NCMAX && int'(A_caddr) < NGMAX) ? a_mem[A_raddr][A_caddr] : '0;
    b_rdata <= (int'(b_addr) < NCMAX) ? b_mem[b_addr] : '0;
  end

  int tests = 0;
  int fails = 0;
  logic nan_model = 1'b0;
  logic [DW+2:0] expq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NMAX; i++) c_mem[i] = $urandom;
    for (int i = 0; i < NMAX; i++)
      for (int j = 0; j < NGMAX; j++) g_mem[i][j] = $urandom;
    for (int r = 0; r < NCMAX; r++)
      for (int j = 0; j < NGMAX; j++) a_mem[r][j] = $urandom;
    for (int r = 0; r < NCMAX; r++) b_mem[r] = $urandom;
  endtask

  // Reference stream: {last, section, word} in transfer order.
  task automatic build_expected(input int n, input int ng, input int nc);
    expq.delete();
    for (int i = 0; i < n; i++) expq.push_back({1'b0, 2'd0, c_mem[i]});
    for (int j = 0; j < ng; j++)
      for (int i = 0; i < n; i++) expq.push_back({1'b0, 2'd1, g_mem[i][j]});
    for (int j = 0; j < ng; j++)
      for (int r = 0; r < nc; r++) expq.push_back({1'b0, 2'd2, a_mem[r][j]});
    for (int r = 0; r < nc; r++) expq.push_back({1'b0, 2'd3, b_mem[r]});
    if (expq.size() > 0) expq[expq.size()-1][DW+2] = 1'b1;
  endtask

  task automatic run(input int n, input int ng, input int nc, input bit rnd_ready, input int want_lat);
    bit bad;
    int total, cyc, first;
    bit prev_stall, got_last;
    logic [DW+2:0] prev_word, e;
    bad = (n > NMAX) || (ng > NGMAX) || (nc > NCMAX);
    expq.delete();
    if (!bad && n > 0) build_expected(n, ng, nc);
    total = expq.size();
    @(negedge clk);
    n_i = NW'(n); ng_i = GW'(ng); nc_i = CW'(nc); start_i = 1'b1;
    nan_model = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    $display("[TB] start n=%0d ng=%0d nc=%0d expect %0d beats", n, ng, nc, total);
    if (total == 0) begin
      check("zero_done", done, 1'b1);
      check("zero_busy", busy, 1'b0);
      check("zero_err", err, bad);
      check("zero_valid", m_valid, 1'b0);
      @(negedge clk);
      check("zero_done_clear", done, 1'b0);
      check("zero_no_beat", m_valid, 1'b0);
      return;
    end
    check("busy_start", busy, 1'b1);
    check("err_legal", err, 1'b0);
    cyc = 1; first = -1; prev_stall = 0; got_last = 0; prev_word = '0;
    while (!got_last && cyc < 4000) begin
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && first < 0) first = cyc;
      if (prev_stall) check("stable", {m_last, m_sec, m_data}, prev_word);
      check("nan_flag", nan_o, nan_model);
      if (ng == 0 && nc == 0)
        check("unused_addr", {G_raddr, G_caddr, A_raddr, A_caddr, b_addr}, '0);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          check("beat", {m_last, m_sec, m_data}, e);
`ifdef CZ_UNLOAD_NAN_FLAG_EN
          if (&e[30:23]) nan_model = 1'b1;
`endif
        end
        got_last = m_last;
        prev_stall = 0;
      end else begin
        prev_stall = m_valid;
        prev_word = {m_last, m_sec, m_data};
      end
      @(negedge clk);
      cyc++;
    end
    check("completed", got_last, 1'b1);
    check("done_pulse", done, 1'b1);
    check("busy_drop", busy, 1'b0);
    check("leftover", expq.size(), 0);
    check("nan_after", nan_o, nan_model);
    if (want_lat > 0) check("first_valid_lat", first, want_lat);
    $display("[TB] transfer n=%0d ng=%0d nc=%0d finished after %0d cycles", n, ng, nc, cyc);
    @(negedge clk);
    check("done_single", done, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {c_addr, G_raddr, G_caddr, A_raddr, A_caddr, b_addr, m_valid, m_data,
                m_sec, m_last, busy, done, err, nan_o}, '0);
  endtask

  initial begin
    int k;
    fill_mem();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    run(2, 1, 1, 0, 3);          // 6 beats, tags 0,0,1,1,2,3
    run(3, 15, 12, 1, 0);        // full size with random back-pressure
    fill_mem();
    run(3, 0, 0, 0, 3);          // center only
    run(4, 1, 1, 0, 0);          // out of range
    check("err_sticky", err, 1'b1);
    run(1, 2, 0, 1, 0);          // legal start clears err
    run(0, 3, 3, 0, 0);          // n=0: no beats, no error
    run(2, 0, 3, 1, 0);          // G and A skipped, b present

    // Reset in the middle of section G with a word waiting.
    fill_mem();
    @(negedge clk);
    n_i = 3'd3; ng_i = 5'd15; nc_i = 5'd12; start_i = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (!(m_valid && m_sec == 2'd1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reached_G", {m_valid, m_sec}, {1'b1, 2'd1});
    rst = 1'b1;
    #1;
    check_all_zero("reset_midG_async");
    @(negedge clk);
    check_all_zero("reset_midG_next");
    rst = 1'b0;
    $display("[TB] reset applied mid-G after %0d cycles", k);
    run(3, 15, 12, 1, 0);

    // Non-finite word in G[1][0].
    fill_mem();
    g_mem[1][0] = 32'h7FC00000;
    run(2, 1, 1, 0, 3);
    run(1, 1, 0, 0, 0);          // new start clears the sticky flag

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
